// File: rtl/fwd_hazard_pkg.sv
// Shared constants and types for the forwarding/hazard unit.
// Latency: n/a (types only).
// Backpressure: n/a.
package fwd_hazard_pkg;

    // Forwarding mux select: 0 picks the register file, k picks producer stage k-1.
    localparam int SEL_RF = 0;

    localparam int CNT_W   = 4;
    // The scoreboard destination field is sized for the widest register address
    // any instance will use; narrower addresses are zero-extended into it.
    localparam int SB_RD_W = 8;

    typedef struct packed {
        logic               busy;
        logic [SB_RD_W-1:0] rd;
        logic [CNT_W-1:0]   cnt;
    } sbEntry_t;

endpackage

// File: rtl/fwd_sel_prio.sv
// Priority match of one source register against the forwarding producer stages.
// Latency: combinational.
// Backpressure: none.
module fwd_sel_prio
    import fwd_hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int NUM_FWD = 2,
    parameter int SELW    = 2
) (
    input  logic [REG_AW-1:0]         src,
    input  logic [NUM_FWD-1:0]        fwdWe,
    input  logic [NUM_FWD*REG_AW-1:0] fwdRd,
    output logic [SELW-1:0]           sel
);

    // Scan oldest to youngest so the youngest matching stage overwrites the result.
    always_comb begin
        sel = SELW'(SEL_RF);
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (fwdWe[k] && (src != '0) && (fwdRd[k*REG_AW +: REG_AW] == src)) begin
                sel = SELW'(k + 1);
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects, load-use/long-latency hazard stalls and a one-entry mul scoreboard.
// Latency: fwd_sel_o/stall_o combinational; mul_done_o MUL_LAT cycles after issue.
// Backpressure: stall_o holds PC/IF-ID; optional stall_cnt_o via FWD_HAZARD_STATS_EN.
module fwd_hazard_unit
    import fwd_hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int NUM_FWD = 2,
    parameter int MUL_LAT = 4,
    localparam int SELW   = $clog2(NUM_FWD + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic [NUM_SRC*REG_AW-1:0] ex_src_i,
    input  logic [NUM_FWD-1:0]        fwd_we_i,
    input  logic [NUM_FWD*REG_AW-1:0] fwd_rd_i,
    input  logic                      ex_memread_i,
    input  logic [REG_AW-1:0]         ex_rd_i,
    input  logic                      id_valid_i,
    input  logic [NUM_SRC*REG_AW-1:0] id_src_i,
    input  logic                      id_we_i,
    input  logic                      id_mul_i,
    input  logic [REG_AW-1:0]         id_rd_i,
    output logic [NUM_SRC*SELW-1:0]   fwd_sel_o,
    output logic                      stall_o,
    output logic                      mul_done_o,
    output logic                      mul_busy_o
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [15:0]               stall_cnt_o
`endif
);

    sbEntry_t sb;
    logic     loadUse;
    logic     rawHit;
    logic     wawHit;
    logic     structHit;
    logic     issue;

    for (genvar s = 0; s < NUM_SRC; s++) begin : gSrc
        fwd_sel_prio #(
            .REG_AW (REG_AW),
            .NUM_FWD(NUM_FWD),
            .SELW   (SELW)
        ) uSel (
            .src  (ex_src_i[s*REG_AW +: REG_AW]),
            .fwdWe(fwd_we_i),
            .fwdRd(fwd_rd_i),
            .sel  (fwd_sel_o[s*SELW +: SELW])
        );
    end

    // sb.rd is never zero while busy, so register 0 cannot raise RAW/WAW hits.
    always_comb begin
        loadUse = 1'b0;
        rawHit  = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (ex_memread_i && (ex_rd_i != '0) && (ex_rd_i == id_src_i[s*REG_AW +: REG_AW])) begin
                loadUse = 1'b1;
            end
            if (sb.busy && (sb.rd == SB_RD_W'(id_src_i[s*REG_AW +: REG_AW]))) begin
                rawHit = 1'b1;
            end
        end
        wawHit    = sb.busy && id_we_i && (sb.rd == SB_RD_W'(id_rd_i));
        structHit = sb.busy && id_mul_i;
    end

    assign stall_o    = id_valid_i && (loadUse || rawHit || wawHit || structHit);
    assign issue      = id_valid_i && id_mul_i && !stall_o && (id_rd_i != '0);
    assign mul_done_o = sb.busy && (sb.cnt == '0);
    assign mul_busy_o = sb.busy;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sb <= '0;
        end else if (issue) begin
            sb <= '{busy: 1'b1, rd: SB_RD_W'(id_rd_i), cnt: CNT_W'(MUL_LAT - 1)};
        end else if (sb.busy) begin
            if (sb.cnt == '0) begin
                sb.busy <= 1'b0;
            end else begin
                sb.cnt <= sb.cnt - 1'b1;
            end
        end
    end

`ifdef FWD_HAZARD_STATS_EN
    logic [15:0] stallCnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stallCnt <= '0;
        end else if (stall_o && (stallCnt != 16'hFFFF)) begin
            stallCnt <= stallCnt + 16'd1;
        end
    end

    assign stall_cnt_o = stallCnt;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Testbench for fwd_hazard_unit: vector table, directed multi-cycle sequences, random vs model.
module tb_fwd_hazard_unit;

    localparam int REG_AW  = 5;
    localparam int NUM_SRC = 2;
    localparam int NUM_FWD = 2;
    localparam int MUL_LAT = 4;
    localparam int SELW    = 2;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_SRC*REG_AW-1:0] ex_src;
    logic [NUM_FWD-1:0]        fwd_we;
    logic [NUM_FWD*REG_AW-1:0] fwd_rd;
    logic                      ex_memread;
    logic [REG_AW-1:0]         ex_rd;
    logic                      id_valid;
    logic [NUM_SRC*REG_AW-1:0] id_src;
    logic                      id_we;
    logic                      id_mul;
    logic [REG_AW-1:0]         id_rd;
    logic [NUM_SRC*SELW-1:0]   fwd_sel;
    logic                      stall;
    logic                      mul_done;
    logic                      mul_busy;
`ifdef FWD_HAZARD_STATS_EN
    logic [15:0]               stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: the pending long-latency op writes back in absolute cycle doneAt.
    int cyc    = 0;
    int pendRd = 0;
    int doneAt = -1;

    always #5 clk = ~clk;

    fwd_hazard_unit #(
        .REG_AW (REG_AW),
        .NUM_SRC(NUM_SRC),
        .NUM_FWD(NUM_FWD),
        .MUL_LAT(MUL_LAT)
    ) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .ex_src_i    (ex_src),
        .fwd_we_i    (fwd_we),
        .fwd_rd_i    (fwd_rd),
        .ex_memread_i(ex_memread),
        .ex_rd_i     (ex_rd),
        .id_valid_i  (id_valid),
        .id_src_i    (id_src),
        .id_we_i     (id_we),
        .id_mul_i    (id_mul),
        .id_rd_i     (id_rd),
        .fwd_sel_o   (fwd_sel),
        .stall_o     (stall),
        .mul_done_o  (mul_done),
        .mul_busy_o  (mul_busy)
`ifdef FWD_HAZARD_STATS_EN
        ,
        .stall_cnt_o (stall_cnt)
`endif
    );

    typedef struct {
        int exSrc0, exSrc1;
        int we0, we1, rd0, rd1;
        int memRd, exRd;
        int idValid, idSrc0, idSrc1;
        int expSel0, expSel1, expStall;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int srcOf(input logic [NUM_SRC*REG_AW-1:0] v, input int s);
        return int'(v[s*REG_AW +: REG_AW]);
    endfunction

    function automatic bit mBusy();
        return doneAt >= 0;
    endfunction

    function automatic int mSel(input int s);
        int src;
        src = srcOf(ex_src, s);
        if (src == 0) return 0;
        for (int k = 0; k < NUM_FWD; k++) begin
            if (fwd_we[k] && int'(fwd_rd[k*REG_AW +: REG_AW]) == src) return k + 1;
        end
        return 0;
    endfunction

    function automatic bit mStall();
        bit st;
        st = 0;
        if (!id_valid) return 0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (ex_memread && ex_rd != 0 && int'(ex_rd) == srcOf(id_src, s)) st = 1;
            if (mBusy() && srcOf(id_src, s) == pendRd) st = 1;
        end
        if (mBusy() && id_we && int'(id_rd) == pendRd) st = 1;
        if (mBusy() && id_mul) st = 1;
        return st;
    endfunction

    task automatic checkModel(input string tag);
        chk({tag, "_sel0"}, int'(fwd_sel[0 +: SELW]), mSel(0));
        chk({tag, "_sel1"}, int'(fwd_sel[SELW +: SELW]), mSel(1));
        chk({tag, "_stall"}, int'(stall), int'(mStall()));
        chk({tag, "_busy"}, int'(mul_busy), int'(mBusy()));
        chk({tag, "_done"}, int'(mul_done), int'(mBusy() && cyc == doneAt));
    endtask

    // Advance one clock edge and update the model from the inputs present at that edge.
    task automatic tick();
        bit iss;
        iss = rst_n && id_valid && id_mul && !mStall() && id_rd != 0;
        @(posedge clk);
        if (!rst_n) begin
            doneAt = -1;
        end else begin
            if (doneAt >= 0 && cyc == doneAt) doneAt = -1;
            if (iss) begin
                pendRd = int'(id_rd);
                doneAt = cyc + MUL_LAT;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle();
        ex_src     = '0;
        fwd_we     = '0;
        fwd_rd     = '0;
        ex_memread = 1'b0;
        ex_rd      = '0;
        id_valid   = 1'b0;
        id_src     = '0;
        id_we      = 1'b0;
        id_mul     = 1'b0;
        id_rd      = '0;
    endtask

    initial begin
        vecs[0] = '{5, 7, 1, 1, 5, 5, 0, 0, 1, 0, 0, 1, 0, 0};
        vecs[1] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        vecs[2] = '{6, 6, 0, 1, 0, 6, 0, 0, 0, 0, 0, 2, 2, 0};
        vecs[3] = '{6, 4, 1, 1, 4, 6, 0, 0, 0, 0, 0, 2, 1, 0};
        vecs[4] = '{0, 0, 0, 0, 0, 0, 1, 8, 1, 8, 0, 0, 0, 1};
        vecs[5] = '{0, 0, 0, 0, 0, 0, 0, 8, 1, 8, 0, 0, 0, 0};
        vecs[6] = '{0, 0, 0, 0, 0, 0, 1, 8, 0, 8, 0, 0, 0, 0};
        vecs[7] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 3, 0, 0, 0, 0};
        vecs[8] = '{0, 0, 0, 0, 0, 0, 1, 12, 1, 3, 12, 0, 0, 1};

        idle();
        rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(mul_busy), 0);
        chk("rst_done", int'(mul_done), 0);
        chk("rst_sel", int'(fwd_sel), 0);
        chk("rst_stall", int'(stall), 0);
        tick();
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            idle();
            ex_src     = {REG_AW'(vecs[i].exSrc1), REG_AW'(vecs[i].exSrc0)};
            fwd_we     = {1'(vecs[i].we1), 1'(vecs[i].we0)};
            fwd_rd     = {REG_AW'(vecs[i].rd1), REG_AW'(vecs[i].rd0)};
            ex_memread = 1'(vecs[i].memRd);
            ex_rd      = REG_AW'(vecs[i].exRd);
            id_valid   = 1'(vecs[i].idValid);
            id_src     = {REG_AW'(vecs[i].idSrc1), REG_AW'(vecs[i].idSrc0)};
            #1;
            chk($sformatf("vec%0d_sel0", i), int'(fwd_sel[0 +: SELW]), vecs[i].expSel0);
            chk($sformatf("vec%0d_sel1", i), int'(fwd_sel[SELW +: SELW]), vecs[i].expSel1);
            chk($sformatf("vec%0d_stall", i), int'(stall), vecs[i].expStall);
            tick();
        end

        // Long-latency op to r9 followed by a dependent consumer.
        idle();
        id_valid = 1'b1;
        id_mul   = 1'b1;
        id_we    = 1'b1;
        id_rd    = 5'd9;
        #1;
        chk("mul_issue_stall", int'(stall), 0);
        chk("mul_issue_busy", int'(mul_busy), 0);
        tick();
        for (int i = 1; i <= 5; i++) begin
            idle();
            id_valid = 1'b1;
            id_src   = {5'd9, 5'd2};
            #1;
            chk($sformatf("raw_T%0d_stall", i), int'(stall), (i <= 4) ? 1 : 0);
            chk($sformatf("raw_T%0d_done", i), int'(mul_done), (i == 4) ? 1 : 0);
            chk($sformatf("raw_T%0d_busy", i), int'(mul_busy), (i <= 4) ? 1 : 0);
            checkModel($sformatf("raw_T%0d_model", i));
            tick();
        end

        // Reset during an in-flight op must cancel it with no late done pulse.
        idle();
        id_valid = 1'b1;
        id_mul   = 1'b1;
        id_rd    = 5'd3;
        tick();
        idle();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(mul_busy), 0);
        chk("arst_done", int'(mul_done), 0);
        fwd_we     = 2'b01;
        fwd_rd     = {5'd0, 5'd3};
        ex_src     = {5'd0, 5'd3};
        ex_memread = 1'b1;
        ex_rd      = 5'd3;
        id_valid   = 1'b1;
        id_src     = {5'd0, 5'd3};
        #1;
        chk("arst_sel0", int'(fwd_sel[0 +: SELW]), 1);
        chk("arst_stall", int'(stall), 1);
        tick();
        tick();
        rst_n = 1'b1;
        idle();
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("arst_post%0d_done", i), int'(mul_done), 0);
            chk($sformatf("arst_post%0d_busy", i), int'(mul_busy), 0);
            tick();
        end

        for (int i = 0; i < 400; i++) begin
            ex_src     = {REG_AW'($urandom_range(0, 7)), REG_AW'($urandom_range(0, 7))};
            fwd_we     = NUM_FWD'($urandom);
            fwd_rd     = {REG_AW'($urandom_range(0, 7)), REG_AW'($urandom_range(0, 7))};
            ex_memread = ($urandom_range(0, 3) == 0);
            ex_rd      = REG_AW'($urandom_range(0, 7));
            id_valid   = ($urandom_range(0, 4) != 0);
            id_src     = {REG_AW'($urandom_range(0, 7)), REG_AW'($urandom_range(0, 7))};
            id_we      = 1'($urandom);
            id_mul     = ($urandom_range(0, 3) == 0);
            id_rd      = REG_AW'($urandom_range(0, 7));
            #1;
            checkModel($sformatf("rnd%0d", i));
            tick();
        end

`ifdef FWD_HAZARD_STATS_EN
        idle();
        rst_n = 1'b0;
        #1;
        chk("stats_rst", int'(stall_cnt), 0);
        tick();
        rst_n = 1'b1;
        ex_memread = 1'b1;
        ex_rd      = 5'd8;
        id_valid   = 1'b1;
        id_src     = {5'd0, 5'd8};
        repeat (65534) @(posedge clk);
        @(negedge clk);
        chk("stats_preload", int'(stall_cnt), 32'hFFFE);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("stats_sat", int'(stall_cnt), 32'hFFFF);
        idle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter NUM_SRC, default 2, source operands per instruction.
REQ-003 SHALL have parameter NUM_FWD, default 2, forwarding producer stages; index 0 is the youngest stage (EX/MEM).
REQ-004 SHALL have parameter MUL_LAT, default 4, long-latency op latency in cycles, legal range 2..15.
REQ-005 SHALL derive SELW = $clog2(NUM_FWD+1).
REQ-006 clk_i  in  1  single clock, rising edge.
REQ-007 rst_n_i  in  1  asynchronous, active-low reset.
REQ-008 ex_src_i  in  NUM_SRC*REG_AW  source registers of the instruction in EX.
REQ-009 fwd_we_i  in  NUM_FWD  write-enable per producer stage.
REQ-010 fwd_rd_i  in  NUM_FWD*REG_AW  destination register per producer stage.
REQ-011 ex_memread_i  in  1  instruction in EX is a load.
REQ-012 ex_rd_i  in  REG_AW  destination of the instruction in EX.
REQ-013 id_valid_i  in  1  ID holds a valid instruction.
REQ-014 id_src_i  in  NUM_SRC*REG_AW  ID source registers.
REQ-015 id_we_i, id_mul_i  in  1 each  ID writes a register; ID is a long-latency op.
REQ-016 id_rd_i  in  REG_AW  ID destination register.
REQ-017 fwd_sel_o  out  NUM_SRC*SELW  per-source mux select: 0 = register file, k = stage k-1.
REQ-018 stall_o  out  1  hold PC and IF/ID, inject a bubble into ID/EX.
REQ-019 mul_done_o  out  1  one-cycle pulse; long-latency result writes back this cycle.
REQ-020 mul_busy_o  out  1  scoreboard entry occupied.

Function
REQ-021 fwd_sel_o SHALL be combinational with zero latency; per source, the lowest-index stage with fwd_we_i=1, fwd_rd_i==src and src!=0 SHALL win; no match SHALL give 0.
REQ-022 Register 0 SHALL never forward, stall or occupy the scoreboard.
REQ-023 Load-use: stall_o SHALL be 1 when id_valid_i, ex_memread_i, ex_rd_i!=0 and ex_rd_i equals any id_src_i.
REQ-024 The scoreboard SHALL be one entry: busy, rd (REG_AW), cnt (4 bit).
REQ-025 An issue SHALL occur when id_valid_i && id_mul_i && !stall_o && id_rd_i!=0; the next state SHALL be busy=1, rd=id_rd_i, cnt=MUL_LAT-1.
REQ-026 While busy, cnt SHALL decrement each cycle; in the cnt==0 cycle mul_done_o=1, and busy SHALL clear at the following edge.
REQ-027 RAW: stall_o SHALL be 1 while busy when any id_src_i equals sb rd; this includes the mul_done_o cycle, and the consumer proceeds the next cycle.
REQ-028 WAW: stall_o SHALL be 1 while busy when id_we_i and id_rd_i equals sb rd.
REQ-029 Structural: stall_o SHALL be 1 while busy when id_mul_i, including the done cycle.
REQ-030 stall_o SHALL be 0 when id_valid_i=0.
REQ-031 Multiple stall causes in one cycle SHALL OR together.
REQ-032 mul_busy_o SHALL equal sb busy.

Reset
REQ-033 rst_n_i low SHALL immediately force busy=0, rd=0, cnt=0, mul_done_o=0 and mul_busy_o=0, including during an in-flight op; no late mul_done_o pulse SHALL occur.
REQ-034 fwd_sel_o and stall_o SHALL follow inputs during reset, with scoreboard terms at 0.

Configuration
REQ-035 With FWD_HAZARD_STATS_EN defined, the block SHALL add output stall_cnt_o[15:0], which counts cycles with stall_o=1, saturates at 16'hFFFF and resets to 0.
REQ-036 Without FWD_HAZARD_STATS_EN, the port and counter SHALL be absent.

Structure
REQ-037 Package fwd_hazard_pkg SHALL hold the select encoding constants (SEL_RF=0) and the scoreboard entry struct typedef.
REQ-038 Sub-module fwd_sel_prio SHALL implement the per-source priority match; it SHALL be instantiated NUM_SRC times.

Verification
REQ-039 NUM_FWD=2; stage0 we=1 rd=5, stage1 we=1 rd=5, ex_src0=5 -> fwd_sel src0=1 (the youngest stage wins).
REQ-040 Stage0 we=1 rd=0, ex_src1=0 -> fwd_sel src1=0, stall_o=0.
REQ-041 ex_memread=1 ex_rd=8, id_src0=8, id_valid=1 -> stall_o=1 for that cycle; with ex_memread=0 the next cycle -> stall_o=0.
REQ-042 MUL_LAT=4; issue mul rd=9 at cycle T, consumer id_src1=9 at T+1 -> stall_o=1 for T+1..T+4, mul_done_o=1 at T+4, stall_o=0 at T+5.
REQ-043 Issue mul rd=3, assert rst_n_i=0 at T+2 -> mul_busy_o=0 immediately and mul_done_o is never asserted.
REQ-044 With FWD_HAZARD_STATS_EN, preload 16'hFFFE, then 3 stall cycles -> stall_cnt_o=16'hFFFF.
